// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter that shares one UART TX engine among NUM_REQ byte requesters.
// Optional UART wait watchdog is built only when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [8*NUM_REQ-1:0]         req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           grant,
  output logic [7:0]                   uart_tx_data,
  output logic                         uart_tx_start,
  input  logic                         uart_tx_busy,
  output logic                         err_timeout,
  output logic [2:0]                   dbg_state_o,
  output logic [$clog2(NUM_REQ)-1:0]   dbg_rr_ptr_o,
  output logic                         dbg_lock_o
);

  // Handshake: a requester raises req[i] with req_data/req_last stable and holds them until
  // req_ack[i] pulses for one cycle (byte latched). uart_tx_start pulses once per byte;
  // uart_tx_data stays put until the next byte is latched.
  // dbg_state_o encoding: 0 IDLE, 1 LOAD, 2 START, 3 WAIT_BUSY, 4 WAIT_DONE.

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 lock_q, lock_d;
  logic                 last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [7:0]           data_q, data_d;
  logic                 start_q, start_d;

  logic                 owner_req;
  logic [IW-1:0]        scan_ptr;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic                 drop_lock;
  logic                 msg_done;
  logic                 tmo_hit;
  logic                 tmo_limit;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] v);
    if (v == IW'(NUM_REQ - 1)) return '0;
    return v + IW'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] v);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  // Scan p, p+1, ... (mod NUM_REQ); walking the offsets downwards lets the nearest one win.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] p);
    logic [IW:0]   res;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, p} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      idx = sum[IW-1:0];
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign owner_req = req[owner_q];
  assign scan_ptr  = (lock_q && !owner_req) ? next_idx(owner_q) : rr_ptr_q;
  assign {pick_found, pick_idx} = rr_pick(req, scan_ptr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
      last_q   <= 1'b0;
      grant_q  <= '0;
      ack_q    <= '0;
      data_q   <= 8'h00;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      start_q  <= start_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    drop_lock = 1'b0;
    msg_done  = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (lock_q && owner_req) begin
          state_d = S_LOAD;
        end else begin
          drop_lock = lock_q;
          if (pick_found) begin
            state_d = S_LOAD;
            owner_d = pick_idx;
          end
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_limit) begin
          state_d = S_IDLE;
          tmo_hit = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_d  = S_IDLE;
          msg_done = last_q;
        end else if (tmo_limit) begin
          state_d = S_IDLE;
          tmo_hit = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lock_d   = lock_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    ack_d    = '0;
    data_d   = data_q;
    last_d   = last_q;
    start_d  = 1'b0;
    if (drop_lock) begin
      lock_d   = 1'b0;
      rr_ptr_d = next_idx(owner_q);
      grant_d  = '0;
    end
    if (state_q == S_IDLE && state_d == S_LOAD) begin
      ack_d   = onehot(owner_d);
      grant_d = onehot(owner_d);
      data_d  = req_data[{owner_d, 3'b000} +: 8];
      last_d  = req_last[owner_d];
    end
    if (state_q == S_LOAD) begin
      lock_d  = 1'b1;
      start_d = 1'b1;
    end
    if (msg_done || tmo_hit) begin
      lock_d   = 1'b0;
      grant_d  = '0;
      rr_ptr_d = next_idx(owner_q);
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] cnt_q, cnt_d;
  logic        err_q;

  assign tmo_limit = (cnt_q == TmoLast);

  // Restarts from zero on every entry into a wait state.
  always_comb begin
    cnt_d = '0;
    if ((state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) && state_d == state_q)
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | tmo_hit;
    end
  end

  assign err_timeout = err_q;
`else
  assign tmo_limit   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign req_ack       = ack_q;
  assign grant         = grant_q;
  assign uart_tx_data  = data_q;
  assign uart_tx_start = start_q;
  assign dbg_state_o   = state_q;
  assign dbg_rr_ptr_o  = rr_ptr_q;
  assign dbg_lock_o    = lock_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized message streams scored
// against a message-level round-robin model. Define UART_TX_ARB_TIMEOUT_EN to cover the watchdog.
module tb_uart_tx_arbiter;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ack;
  logic [1:0]  grant;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy;
  logic        err_timeout;
  logic [2:0]  dbg_state;
  logic        dbg_rr_ptr;
  logic        dbg_lock;

  int checks;
  int failures;
  logic uart_en;

  logic [8:0] exp_q[$];
  logic [8:0] src_bytes [2][16];
  int         src_cnt [2];
  int         src_rd [2];

  uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ack       (req_ack),
    .grant         (grant),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_busy  (uart_tx_busy),
    .err_timeout   (err_timeout),
    .dbg_state_o   (dbg_state),
    .dbg_rr_ptr_o  (dbg_rr_ptr),
    .dbg_lock_o    (dbg_lock)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0; req_data = '0; req_last = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // UART engine model: busy rises 1-2 cycles after start and lasts 1-4 cycles.
  initial begin
    int d;
    int len;
    uart_tx_busy = 1'b0;
    forever begin
      tick();
      if (uart_en && uart_tx_start === 1'b1) begin
        d = $urandom_range(1, 2);
        repeat (d) tick();
        uart_tx_busy = 1'b1;
        len = $urandom_range(1, 4);
        repeat (len) tick();
        uart_tx_busy = 1'b0;
      end
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (dbg_state !== ST_IDLE && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL %s_idle_wait: state %0d required %0d", tag, dbg_state, ST_IDLE);
    end
  endtask

  task automatic present_req(input int i);
    if (src_rd[i] < src_cnt[i]) begin
      req[i]            = 1'b1;
      req_data[8*i +: 8] = src_bytes[i][src_rd[i]][7:0];
      req_last[i]       = src_bytes[i][src_rd[i]][8];
    end else begin
      req[i]      = 1'b0;
      req_last[i] = 1'b0;
    end
  endtask

  // driver tasks / scenarios
  task automatic test_reset();
    reset = 1'b0;
    req = '0; req_data = '0; req_last = '0;
    uart_en = 1'b1;
    #3;
    checks++; if (req_ack !== 2'b00) begin failures++; $display("FAIL rst_ack: got %b required 00", req_ack); end
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rst_grant: got %b required 00", grant); end
    checks++; if (uart_tx_start !== 1'b0) begin failures++; $display("FAIL rst_start: got %b required 0", uart_tx_start); end
    checks++; if (uart_tx_data !== 8'h00) begin failures++; $display("FAIL rst_data: got %h required 00", uart_tx_data); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL rst_err: got %b required 0", err_timeout); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state: got %0d required 0", dbg_state); end
    checks++; if (dbg_rr_ptr !== 1'b0) begin failures++; $display("FAIL rst_rr_ptr: got %b required 0", dbg_rr_ptr); end
    checks++; if (dbg_lock !== 1'b0) begin failures++; $display("FAIL rst_lock: got %b required 0", dbg_lock); end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    do_reset();
    req = 2'b01; req_data = 16'h0041; req_last = 2'b01;
    tick();
    checks++; if (req_ack !== 2'b01) begin failures++; $display("FAIL single_ack: got %b required 01", req_ack); end
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL single_grant: got %b required 01", grant); end
    checks++; if (uart_tx_start !== 1'b0) begin failures++; $display("FAIL single_early_start: got %b required 0", uart_tx_start); end
    req = 2'b00; req_last = 2'b00;
    tick();
    checks++; if (uart_tx_start !== 1'b1) begin failures++; $display("FAIL single_start: got %b required 1", uart_tx_start); end
    checks++; if (uart_tx_data !== 8'h41) begin failures++; $display("FAIL single_data: got %h required 41", uart_tx_data); end
    checks++; if (req_ack !== 2'b00) begin failures++; $display("FAIL single_ack_pulse: got %b required 00", req_ack); end
    wait_idle(50, "single");
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL single_grant_release: got %b required 00", grant); end
    checks++; if (dbg_rr_ptr !== 1'b1) begin failures++; $display("FAIL single_rr_ptr: got %b required 1", dbg_rr_ptr); end
    checks++; if (dbg_lock !== 1'b0) begin failures++; $display("FAIL single_lock: got %b required 0", dbg_lock); end
  endtask

  task automatic test_alternate();
    logic [7:0] exp_alt [4];
    int n;
    exp_alt = '{8'hA0, 8'hB0, 8'hA0, 8'hB0};
    do_reset();
    req = 2'b11; req_data = 16'hB0A0; req_last = 2'b11;
    n = 0;
    for (int cyc = 0; cyc < 300 && n < 4; cyc++) begin
      tick();
      if (uart_tx_start === 1'b1) begin
        checks++;
        if (uart_tx_data !== exp_alt[n]) begin
          failures++;
          $display("FAIL alt_order[%0d]: got %h required %h", n, uart_tx_data, exp_alt[n]);
        end
        n++;
        if (n == 4) begin req = 2'b00; req_last = 2'b00; end
      end
    end
    checks++; if (n != 4) begin failures++; $display("FAIL alt_count: got %0d bytes required 4", n); end
    wait_idle(50, "alt");
  endtask

  task automatic test_message_lock();
    logic [7:0] exp_d [4];
    logic [1:0] exp_g [4];
    int n;
    int b0;
    int early;
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h55};
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b10};
    req = 2'b11; req_data = 16'h5510; req_last = 2'b10;
    n = 0; b0 = 0; early = 0;
    for (int cyc = 0; cyc < 400 && n < 4; cyc++) begin
      tick();
      if (req_ack[1] === 1'b1) begin
        if (n < 3) early++;
        req[1] = 1'b0; req_last[1] = 1'b0;
      end
      if (req_ack[0] === 1'b1) begin
        b0++;
        if (b0 < 3) begin
          req_data[7:0] = 8'h10 + 8'(b0);
          req_last[0]   = (b0 == 2);
        end else begin
          req[0] = 1'b0; req_last[0] = 1'b0;
        end
      end
      if (uart_tx_start === 1'b1) begin
        checks++;
        if (uart_tx_data !== exp_d[n] || grant !== exp_g[n]) begin
          failures++;
          $display("FAIL lock_byte[%0d]: got data %h grant %b required data %h grant %b",
                   n, uart_tx_data, grant, exp_d[n], exp_g[n]);
        end
        n++;
      end
    end
    checks++; if (early != 0) begin failures++; $display("FAIL lock_ack_out_of_turn: got %0d acks required 0", early); end
    checks++; if (n != 4) begin failures++; $display("FAIL lock_count: got %0d bytes required 4", n); end
    wait_idle(50, "lock");
  endtask

  task automatic test_owner_drop();
    logic [7:0] exp_d [2];
    logic [1:0] exp_g [2];
    int n;
    exp_d = '{8'h20, 8'h21};
    exp_g = '{2'b01, 2'b10};
    req = 2'b11; req_data = 16'h2120; req_last = 2'b10;
    n = 0;
    for (int cyc = 0; cyc < 300 && n < 2; cyc++) begin
      tick();
      if (req_ack[0] === 1'b1) req[0] = 1'b0;
      if (req_ack[1] === 1'b1) begin
        checks++;
        if (dbg_rr_ptr !== 1'b1) begin failures++; $display("FAIL drop_rr_after_release: got %b required 1", dbg_rr_ptr); end
        req[1] = 1'b0; req_last[1] = 1'b0;
      end
      if (uart_tx_start === 1'b1) begin
        checks++;
        if (uart_tx_data !== exp_d[n] || grant !== exp_g[n]) begin
          failures++;
          $display("FAIL drop_byte[%0d]: got data %h grant %b required data %h grant %b",
                   n, uart_tx_data, grant, exp_d[n], exp_g[n]);
        end
        n++;
      end
    end
    checks++; if (n != 2) begin failures++; $display("FAIL drop_count: got %0d bytes required 2", n); end
    wait_idle(50, "drop");
    checks++; if (dbg_rr_ptr !== 1'b0) begin failures++; $display("FAIL drop_rr_wrap: got %b required 0", dbg_rr_ptr); end
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL drop_grant: got %b required 00", grant); end
  endtask

  task automatic test_reset_mid_message();
    int n;
    int seen;
    req = 2'b01; req_data = 16'h0030; req_last = 2'b01;
    n = 0;
    while (dbg_state !== ST_WAIT_DONE && n < 40) begin
      tick();
      if (req_ack[0] === 1'b1) begin req = 2'b00; req_last = 2'b00; end
      n++;
    end
    checks++; if (dbg_state !== ST_WAIT_DONE) begin failures++; $display("FAIL rmid_reach: state %0d required %0d", dbg_state, ST_WAIT_DONE); end
    reset = 1'b0;
    #2;
    checks++; if (grant !== 2'b00 || req_ack !== 2'b00 || uart_tx_start !== 1'b0)
      begin failures++; $display("FAIL rmid_ctrl: got grant %b ack %b start %b required 00 00 0", grant, req_ack, uart_tx_start); end
    checks++; if (uart_tx_data !== 8'h00) begin failures++; $display("FAIL rmid_data: got %h required 00", uart_tx_data); end
    checks++; if (dbg_state !== ST_IDLE || dbg_lock !== 1'b0 || dbg_rr_ptr !== 1'b0)
      begin failures++; $display("FAIL rmid_state: got state %0d lock %b rr %b required 0 0 0", dbg_state, dbg_lock, dbg_rr_ptr); end
    n = 0;
    while (uart_tx_busy !== 1'b0 && n < 20) begin tick(); n++; end
    tick();
    reset = 1'b1;
    tick();
    req = 2'b10; req_data = 16'h3100; req_last = 2'b10;
    seen = 0;
    for (int cyc = 0; cyc < 40 && seen == 0; cyc++) begin
      tick();
      if (req_ack[1] === 1'b1) begin req = 2'b00; req_last = 2'b00; end
      if (uart_tx_start === 1'b1) begin
        seen = 1;
        checks++;
        if (uart_tx_data !== 8'h31 || grant !== 2'b10) begin
          failures++;
          $display("FAIL rmid_after: got data %h grant %b required 31 10", uart_tx_data, grant);
        end
      end
    end
    checks++; if (seen == 0) begin failures++; $display("FAIL rmid_after_start: got none required one start"); end
    wait_idle(50, "rmid");
    checks++; if (dbg_rr_ptr !== 1'b0) begin failures++; $display("FAIL rmid_rr_wrap: got %b required 0", dbg_rr_ptr); end
  endtask

  task automatic test_timeout();
    int n;
    int started;
    int waits;
    uart_en = 1'b0;
    req = 2'b01; req_data = 16'h0040; req_last = 2'b01;
    started = 0;
    for (int cyc = 0; cyc < 20 && started == 0; cyc++) begin
      tick();
      if (req_ack[0] === 1'b1) begin req = 2'b00; req_last = 2'b00; end
      if (uart_tx_start === 1'b1) started = 1;
    end
    checks++; if (started == 0) begin failures++; $display("FAIL tmo_start: got none required one start"); end
`ifdef UART_TX_ARB_TIMEOUT_EN
    waits = 0;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (dbg_state === ST_WAIT_BUSY) waits++;
      else break;
    end
    checks++; if (waits != 16) begin failures++; $display("FAIL tmo_wait_cycles: got %0d required 16", waits); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL tmo_state: got %0d required 0", dbg_state); end
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_err: got %b required 1", err_timeout); end
    checks++; if (grant !== 2'b00 || dbg_rr_ptr !== 1'b1)
      begin failures++; $display("FAIL tmo_release: got grant %b rr %b required 00 1", grant, dbg_rr_ptr); end
    uart_en = 1'b1;
    req = 2'b10; req_data = 16'h4100; req_last = 2'b10;
    started = 0;
    for (int cyc = 0; cyc < 40 && started == 0; cyc++) begin
      tick();
      if (req_ack[1] === 1'b1) begin req = 2'b00; req_last = 2'b00; end
      if (uart_tx_start === 1'b1) begin
        started = 1;
        checks++;
        if (uart_tx_data !== 8'h41) begin failures++; $display("FAIL tmo_next_data: got %h required 41", uart_tx_data); end
      end
    end
    checks++; if (started == 0) begin failures++; $display("FAIL tmo_next_start: got none required one start"); end
    wait_idle(50, "tmo");
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_sticky: got %b required 1", err_timeout); end
`else
    waits = 0;
    n = 0;
    repeat (40) tick();
    checks++; if (dbg_state !== ST_WAIT_BUSY) begin failures++; $display("FAIL nowd_state: got %0d required %0d", dbg_state, ST_WAIT_BUSY); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL nowd_err: got %b required 0", err_timeout); end
    uart_en = 1'b1;
    do_reset();
`endif
  endtask

  // Reference: message-level round robin over requesters that still hold messages.
  task automatic test_random();
    int nm;
    int nb;
    int mrd [2];
    int ptr;
    int sel;
    logic [8:0] e;
    logic [8:0] got;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
        src_cnt[i] = 0;
        src_rd[i]  = 0;
        nm = $urandom_range(1, 4);
        for (int m = 0; m < nm; m++) begin
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) begin
            src_bytes[i][src_cnt[i]] = {(b == nb - 1), 8'($urandom)};
            src_cnt[i]++;
          end
        end
      end
      mrd[0] = 0; mrd[1] = 0; ptr = 0;
      while (mrd[0] < src_cnt[0] || mrd[1] < src_cnt[1]) begin
        sel = (mrd[ptr] < src_cnt[ptr]) ? ptr : 1 - ptr;
        do begin
          e = src_bytes[sel][mrd[sel]];
          mrd[sel]++;
          exp_q.push_back({sel[0], e[7:0]});
        end while (!e[8]);
        ptr = (sel + 1) % 2;
      end
      present_req(0);
      present_req(1);
      for (int cyc = 0; cyc < 3000 && (exp_q.size() > 0 || dbg_state !== ST_IDLE); cyc++) begin
        tick();
        if (req_ack !== 2'b00) begin
          checks++;
          if (req_ack !== grant) begin failures++; $display("FAIL rnd_ack_grant: got ack %b grant %b required equal", req_ack, grant); end
          for (int i = 0; i < 2; i++) begin
            if (req_ack[i] === 1'b1) begin
              src_rd[i]++;
              present_req(i);
            end
          end
        end
        if (uart_tx_start === 1'b1) begin
          checks++;
          got = {grant[1], uart_tx_data};
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rnd_extra_byte: got %h required no byte", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e || !$onehot(grant)) begin
              failures++;
              $display("FAIL rnd_byte: got owner/data %h grant %b required %h", got, grant, e);
            end
          end
        end
      end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_drain: got %0d bytes left required 0", exp_q.size()); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    uart_en  = 1'b1;
    test_reset();
    test_single_byte();
    test_alternate();
    test_message_lock();
    test_owner_drop();
    test_reset_mid_message();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
